// File: rtl/tinyml_cam_rgb_to_raw_if.sv
// tinyml_cam_rgb_to_raw_if: 2PPC RGB in / 3-row Bayer window out stream bundle
//   i_vsync, i_valid, i_r, i_g, i_b : RGB source side (driven by master)
//   o_vsync, o_valid, o_p_01/00/11  : Bayer window side (driven by slave)
interface tinyml_cam_rgb_to_raw_if #(
   parameter int P_DEPTH = 10
) ();
   localparam int PW = P_DEPTH * 2;
   logic          i_vsync;
   logic          i_valid;
   logic [PW-1:0] i_r;
   logic [PW-1:0] i_g;
   logic [PW-1:0] i_b;
   logic          o_vsync;
   logic          o_valid;
   logic [PW-1:0] o_p_01;
   logic [PW-1:0] o_p_00;
   logic [PW-1:0] o_p_11;
   modport slave (
      input  i_vsync, i_valid, i_r, i_g, i_b,
      output o_vsync, o_valid, o_p_01, o_p_00, o_p_11
   );
   modport master (
      output i_vsync, i_valid, i_r, i_g, i_b,
      input  o_vsync, o_valid, o_p_01, o_p_00, o_p_11
   );
endinterface

// File: rtl/tinyml_cam_rgb_to_raw.sv
// tinyml_cam_rgb_to_raw: re-mosaic 2PPC RGB into RGGB RAW as a 3-row window
//   i_pclk  : pixel clock, rising edge
//   i_arstn : asynchronous active-low reset
//   cam     : slave stream bundle (RGB beat in, Bayer window beat out, 1-cycle latency)
module tinyml_cam_rgb_to_raw #(
   parameter int P_DEPTH      = 10,
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480
) (
   input logic                     i_pclk,
   input logic                     i_arstn,
   tinyml_cam_rgb_to_raw_if.slave  cam
);
   localparam int PW    = P_DEPTH * 2;
   localparam int BEATS = FRAME_WIDTH / 2;
   localparam int XW    = $clog2(BEATS);
   localparam int YW    = $clog2(FRAME_HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(BEATS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);
   logic [XW-1:0] x, cur_x;
   logic [YW-1:0] y, cur_y, y_q;
   logic          vsync_q, sof;
   logic          vsync_o, valid_o;
   logic [PW-1:0] mosaic, p01_q, rd0, rd1;
   logic [PW-1:0] lb0 [BEATS];
   logic [PW-1:0] lb1 [BEATS];
   // a vsync falling edge makes the beat on the same cycle x=0,y=0
   assign sof    = ~cam.i_vsync & vsync_q;
   assign cur_x  = sof ? '0 : x;
   assign cur_y  = sof ? '0 : y;
   assign mosaic = cur_y[0] ? {cam.i_b[PW-1:P_DEPTH], cam.i_g[P_DEPTH-1:0]}
                            : {cam.i_g[PW-1:P_DEPTH], cam.i_r[P_DEPTH-1:0]};
   always_ff @(posedge i_pclk or negedge i_arstn) begin
      if (!i_arstn) begin
         x       <= '0;
         y       <= '0;
         y_q     <= '0;
         vsync_q <= 1'b0;
         vsync_o <= 1'b0;
         valid_o <= 1'b0;
         p01_q   <= '0;
      end else begin
         vsync_q <= cam.i_vsync;
         vsync_o <= cam.i_vsync;
         valid_o <= cam.i_valid;
         if (cam.i_valid) begin
            x     <= cur_x == X_LAST ? '0 : cur_x + 1'b1;
            y     <= cur_x == X_LAST && cur_y != Y_LAST ? cur_y + 1'b1 : cur_y;
            y_q   <= cur_y;
            p01_q <= mosaic;
         end else if (sof) begin
            x <= '0;
            y <= '0;
         end
      end
   end
   // line buffers are never cleared; row masking below hides stale contents
   always_ff @(posedge i_pclk) begin
      if (cam.i_valid) begin
         rd0        <= lb0[cur_x];
         rd1        <= lb1[cur_x];
         lb0[cur_x] <= mosaic;
         lb1[cur_x] <= lb0[cur_x];
      end
   end
   assign cam.o_vsync = vsync_o;
   assign cam.o_valid = valid_o;
   assign cam.o_p_01  = valid_o ? p01_q : '0;
   assign cam.o_p_00  = valid_o && y_q != '0 ? rd0 : '0;
   assign cam.o_p_11  = valid_o && y_q > YW'(1) ? rd1 : '0;
endmodule

// File: tb/tb_tinyml_cam_rgb_to_raw.sv
// tb_tinyml_cam_rgb_to_raw: scoreboard bench for the RGB-to-Bayer window source
module tb_tinyml_cam_rgb_to_raw;
   localparam int P  = 10;
   localparam int PW = 2 * P;
   localparam int FW = 8;
   localparam int FH = 4;
   localparam int B  = FW / 2;
   typedef struct {
      logic [PW-1:0] p01;
      logic [PW-1:0] p00;
      logic [PW-1:0] p11;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int nchk = 0;
   int nerr = 0;
   exp_t q[$];
   logic [PW-1:0] hist [int];
   int mx = 0, my = 0;
   bit mvs_q = 1'b0;
   tinyml_cam_rgb_to_raw_if #(.P_DEPTH(P)) bus ();
   tinyml_cam_rgb_to_raw #(.P_DEPTH(P), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) dut (
      .i_pclk(clk),
      .i_arstn(rst_n),
      .cam(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      nchk++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s got %h expected %h (line %0d beat %0d)", tag, got, exp, my, mx);
      end
   endtask
   task automatic chk_zero();
      chk("rst_vsync", PW'(bus.o_vsync), '0);
      chk("rst_valid", PW'(bus.o_valid), '0);
      chk("rst_p01", bus.o_p_01, '0);
      chk("rst_p00", bus.o_p_00, '0);
      chk("rst_p11", bus.o_p_11, '0);
   endtask
   task automatic beat(input bit vs, input bit v, input logic [PW-1:0] r, g, b);
      exp_t e;
      int ys;
      logic [PW-1:0] w;
      bus.i_vsync = vs;
      bus.i_valid = v;
      bus.i_r = r;
      bus.i_g = g;
      bus.i_b = b;
      if (!vs && mvs_q) begin
         mx = 0;
         my = 0;
         hist.delete();
      end
      if (v) begin
         ys = my > FH - 1 ? FH - 1 : my;
         w = ys % 2 == 0 ? {g[PW-1:P], r[P-1:0]} : {b[PW-1:P], g[P-1:0]};
         e.p01 = w;
         e.p00 = ys >= 1 ? hist[(my - 1) * B + mx] : '0;
         e.p11 = ys >= 2 ? hist[(my - 2) * B + mx] : '0;
         hist[my * B + mx] = w;
         q.push_back(e);
         mx++;
         if (mx == B) begin
            mx = 0;
            my++;
         end
      end
      mvs_q = vs;
      @(posedge clk);
      #1;
      chk("vsync", PW'(bus.o_vsync), PW'(vs));
      chk("valid", PW'(bus.o_valid), PW'(v));
      if (v && q.size() > 0) e = q.pop_front();
      else e = '{'0, '0, '0};
      chk("p01", bus.o_p_01, e.p01);
      chk("p00", bus.o_p_00, e.p00);
      chk("p11", bus.o_p_11, e.p11);
   endtask
   function automatic logic [PW-1:0] pix(input int kind, input int l, input int bx, input int c);
      logic [PW-1:0] w;
      for (int ln = 0; ln < 2; ln++) begin
         int v;
         v = 16 * l + 2 * bx + ln;
         w[ln*P +: P] = kind == 0 ? (c == 0 ? P'(10'h3FF) : c == 1 ? P'(10'h155) : P'(10'h0AA))
                      : kind == 1 ? P'(v + 256 * c)
                      : P'(10'h3FF);
      end
      return w;
   endfunction
   task automatic send_frame(input int kind, input int nlines, input bit gaps, input int stop_at);
      repeat (2) beat(1'b1, 1'b0, PW'($urandom), PW'($urandom), PW'($urandom));
      for (int l = 0; l < nlines; l++) begin
         for (int bx = 0; bx < B; bx++) begin
            if (l * B + bx == stop_at) return;
            if (gaps && (l + bx) != 0 && $urandom_range(0, 2) == 0)
               beat(1'b0, 1'b0, PW'($urandom), PW'($urandom), PW'($urandom));
            beat(1'b0, 1'b1, pix(kind, l, bx, 0), pix(kind, l, bx, 1), pix(kind, l, bx, 2));
         end
      end
      beat(1'b0, 1'b0, '0, '0, '0);
   endtask
   initial begin
      bus.i_vsync = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_r = '0;
      bus.i_g = '0;
      bus.i_b = '0;
      #12;
      chk_zero();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_frame(0, FH, 1'b0, -1);
      send_frame(1, FH, 1'b0, -1);
      send_frame(2, FH, 1'b0, -1);
      send_frame(1, FH, 1'b0, -1);
      send_frame(1, FH, 1'b1, -1);
      send_frame(1, 6, 1'b0, -1);
      send_frame(1, 6, 1'b1, -1);
      send_frame(2, 2, 1'b0, B + 2);
      rst_n = 1'b0;
      #1;
      chk_zero();
      bus.i_valid = 1'b1;
      bus.i_vsync = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk_zero();
      end
      bus.i_valid = 1'b0;
      q.delete();
      mvs_q = 1'b0;
      mx = 0;
      my = 0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mvs_q = bus.i_vsync;
      send_frame(0, FH, 1'b0, -1);
      send_frame(1, FH, 1'b0, -1);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
